// File: rtl/mem_stage_if.sv
// Data-memory port (req/gnt/rvalid, single outstanding) plus the LSU op type shared by MEM and its bench.
package mem_stage_pkg;
  typedef enum logic {LSU_LD = 1'b0, LSU_ST = 1'b1} lsu_op_e;
endpackage

interface mem_stage_if;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );
  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: drives the data bus for loads/stores, aligns/extends data,
// registers results into WB and exposes the MEM forwarding port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit MISALIGN_EXC_EN = 1'b1,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_M,
  input  logic                 flush_M,
  output logic                 ready_mem,
  input  logic                 lsu_en_mem,
  input  lsu_op_e              lsu_op_mem,
  input  logic [2:0]           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic [31:0]          lsu_wdata_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic [31:0]          pc_mem,
  input  logic                 exc_taken_mem,
  mem_stage_if.master          dbus,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic [31:0]          pc_wb,
  output logic                 exc_taken_wb,
  output logic                 misaligned_wb,
  output logic                 forward_mem_en,
  output logic [TAG_WIDTH-1:0] forward_mem_tag,
  output logic [4:0]           forward_mem_addr,
  output logic [31:0]          forward_mem_wdata
);
  typedef enum logic [1:0] {IDLE, WAIT_RV, DONE, DRAIN} state_e;

  state_e      state_q;
  logic [31:0] buf_q;

  logic [1:0]  dt, off;
  logic        is_h, is_w, misalign, exc_any, access, is_ld;
  logic        leave, complete;
  logic [31:0] rdata_sel, shifted, ld_res, wb_data_d;

  assign dt       = lsu_dtype_mem[1:0];
  assign is_h     = (dt == 2'b01);
  assign is_w     = dt[1];
  assign misalign = MISALIGN_EXC_EN && lsu_en_mem &&
                    ((is_h && lsu_addr_mem[0]) || (is_w && (|lsu_addr_mem[1:0])));
  // With exceptions disabled the low address bits are simply dropped to the access size.
  assign off      = MISALIGN_EXC_EN ? lsu_addr_mem[1:0] :
                    is_w ? 2'b00 : is_h ? {lsu_addr_mem[1], 1'b0} : lsu_addr_mem[1:0];
  assign exc_any  = exc_taken_mem | misalign;
  assign access   = lsu_en_mem & ~exc_any;
  assign is_ld    = lsu_en_mem & (lsu_op_mem == LSU_LD);

  assign dbus.data_req  = (state_q == IDLE) & access & ~stall_M & ~flush_M;
  assign dbus.data_addr = {lsu_addr_mem[31:2], 2'b00};
  assign dbus.data_we   = (lsu_op_mem == LSU_ST);

  always_comb begin
    dbus.data_be    = 4'hF;
    dbus.data_wdata = lsu_wdata_mem;
    case (dt)
      2'b00: begin
        dbus.data_be    = 4'b0001 << off;
        dbus.data_wdata = {4{lsu_wdata_mem[7:0]}};
      end
      2'b01: begin
        dbus.data_be    = 4'b0011 << {off[1], 1'b0};
        dbus.data_wdata = {2{lsu_wdata_mem[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdata_sel = (state_q == DONE) ? buf_q : dbus.data_rdata;
  assign shifted   = rdata_sel >> {off, 3'b000};

  always_comb begin
    ld_res = shifted;
    case (dt)
      2'b00:   ld_res = lsu_dtype_mem[2] ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_res = lsu_dtype_mem[2] ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // leave: the instruction in MEM is finished with (completed or discarded) this cycle.
  always_comb begin
    leave = 1'b0;
    case (state_q)
      IDLE:    leave = ~access | flush_M;
      WAIT_RV: leave = dbus.data_rvalid;
      DONE:    leave = 1'b1;
      DRAIN:   leave = 1'b0;
      default: leave = 1'b0;
    endcase
  end

  assign complete  = leave & ~stall_M & ~flush_M;
  assign ready_mem = leave & ~stall_M;
  assign wb_data_d = is_ld ? ld_res : rd_wr_data_mem;

  assign forward_mem_en    = rd_wr_en_mem & complete & ~exc_any;
  assign forward_mem_tag   = rd_wr_tag_mem;
  assign forward_mem_addr  = rd_wr_addr_mem;
  assign forward_mem_wdata = wb_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      rd_wr_en_wb   <= 1'b0;
      rd_wr_tag_wb  <= '0;
      rd_wr_addr_wb <= '0;
      rd_wr_data_wb <= '0;
      pc_wb         <= '0;
      exc_taken_wb  <= 1'b0;
      misaligned_wb <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (dbus.data_req && dbus.data_gnt) state_q <= WAIT_RV;
        WAIT_RV: begin
          if (dbus.data_rvalid) begin
            if (!flush_M && stall_M) begin
              buf_q   <= dbus.data_rdata;
              state_q <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush_M) begin
            state_q <= DRAIN;
          end
        end
        DONE:    if (flush_M || !stall_M) state_q <= IDLE;
        DRAIN:   if (dbus.data_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (flush_M || (!stall_M && !complete)) begin
        rd_wr_en_wb   <= 1'b0;
        exc_taken_wb  <= 1'b0;
        misaligned_wb <= 1'b0;
      end else if (complete) begin
        rd_wr_en_wb   <= rd_wr_en_mem & ~exc_any;
        rd_wr_tag_wb  <= rd_wr_tag_mem;
        rd_wr_addr_wb <= rd_wr_addr_mem;
        rd_wr_data_wb <= wb_data_d;
        pc_wb         <= pc_mem;
        exc_taken_wb  <= exc_any;
        misaligned_wb <= misalign;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of zero-wait loads/stores plus hand-written multi-cycle cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_M, flush_M, ready_mem;
  logic        lsu_en_mem;
  lsu_op_e     lsu_op_mem;
  logic [2:0]  lsu_dtype_mem;
  logic [31:0] lsu_addr_mem, lsu_wdata_mem;
  logic        rd_wr_en_mem;
  logic [3:0]  rd_wr_tag_mem;
  logic [4:0]  rd_wr_addr_mem;
  logic [31:0] rd_wr_data_mem, pc_mem;
  logic        exc_taken_mem;
  logic        rd_wr_en_wb;
  logic [3:0]  rd_wr_tag_wb;
  logic [4:0]  rd_wr_addr_wb;
  logic [31:0] rd_wr_data_wb, pc_wb;
  logic        exc_taken_wb, misaligned_wb;
  logic        forward_mem_en;
  logic [3:0]  forward_mem_tag;
  logic [4:0]  forward_mem_addr;
  logic [31:0] forward_mem_wdata;

  mem_stage_if bus();

  mem_stage #(.MISALIGN_EXC_EN(1'b1), .TAG_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .stall_M(stall_M), .flush_M(flush_M), .ready_mem(ready_mem),
    .lsu_en_mem(lsu_en_mem), .lsu_op_mem(lsu_op_mem), .lsu_dtype_mem(lsu_dtype_mem),
    .lsu_addr_mem(lsu_addr_mem), .lsu_wdata_mem(lsu_wdata_mem),
    .rd_wr_en_mem(rd_wr_en_mem), .rd_wr_tag_mem(rd_wr_tag_mem), .rd_wr_addr_mem(rd_wr_addr_mem),
    .rd_wr_data_mem(rd_wr_data_mem), .pc_mem(pc_mem), .exc_taken_mem(exc_taken_mem),
    .dbus(bus),
    .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_tag_wb(rd_wr_tag_wb), .rd_wr_addr_wb(rd_wr_addr_wb),
    .rd_wr_data_wb(rd_wr_data_wb), .pc_wb(pc_wb), .exc_taken_wb(exc_taken_wb),
    .misaligned_wb(misaligned_wb),
    .forward_mem_en(forward_mem_en), .forward_mem_tag(forward_mem_tag),
    .forward_mem_addr(forward_mem_addr), .forward_mem_wdata(forward_mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_en_mem = 1'b0; lsu_op_mem = LSU_LD; lsu_dtype_mem = 3'b010;
    lsu_addr_mem = '0; lsu_wdata_mem = '0;
    rd_wr_en_mem = 1'b0; rd_wr_tag_mem = '0; rd_wr_addr_mem = '0; rd_wr_data_mem = '0;
    pc_mem = '0; exc_taken_mem = 1'b0; stall_M = 1'b0; flush_M = 1'b0;
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = '0;
  endtask

  task automatic drive_lsu(input logic st, input logic [2:0] dt, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] pc);
    lsu_en_mem = 1'b1; lsu_op_mem = st ? LSU_ST : LSU_LD; lsu_dtype_mem = dt;
    lsu_addr_mem = a; lsu_wdata_mem = wd;
    rd_wr_en_mem = ~st; rd_wr_tag_mem = 4'h3; rd_wr_addr_mem = 5'd7;
    rd_wr_data_mem = 32'h5555_AAAA; pc_mem = pc; exc_taken_mem = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bus_wd;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 4'b1000, 32'h0, 32'hFFFF_FF80}; // LB
    vecs[1] = '{1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h80AA_BBCC, 4'b0010, 32'h0, 32'h0000_00BB}; // LBU
    vecs[2] = '{1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 4'b1100, 32'h0, 32'hFFFF_80AA}; // LH
    vecs[3] = '{1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h80AA_BBCC, 4'b0011, 32'h0, 32'h0000_BBCC}; // LHU
    vecs[4] = '{1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678}; // LW
    vecs[5] = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0}; // SH
    vecs[6] = '{1'b1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0}; // SB
    vecs[7] = '{1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0}; // SW

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, bus.data_req}, 32'h0);
    chk("rst_wb_en", {31'h0, rd_wr_en_wb}, 32'h0);
    chk("rst_wb_data", rd_wr_data_wb, 32'h0);
    chk("rst_pc_wb", pc_wb, 32'h0);
    chk("rst_exc_wb", {31'h0, exc_taken_wb}, 32'h0);
    reset = 1'b0;

    // Stray response with nothing outstanding must not disturb anything.
    @(negedge clk); bus.data_rvalid = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    @(negedge clk); bus.data_rvalid = 1'b0;
    #1 chk("stray_rv_ready", {31'h0, ready_mem}, 32'h1);
    chk("stray_rv_wb_en", {31'h0, rd_wr_en_wb}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_lsu(vecs[i].st, vecs[i].dt, vecs[i].addr, vecs[i].wd, 32'h400 + 32'(i * 4));
      bus.data_gnt = 1'b1;
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, bus.data_req}, 32'h1);
      chk($sformatf("v%0d_addr", i), bus.data_addr, {vecs[i].addr[31:2], 2'b00});
      chk($sformatf("v%0d_be", i), {28'h0, bus.data_be}, {28'h0, vecs[i].be});
      chk($sformatf("v%0d_we", i), {31'h0, bus.data_we}, {31'h0, vecs[i].st});
      chk($sformatf("v%0d_ready0", i), {31'h0, ready_mem}, 32'h0);
      if (vecs[i].st) chk($sformatf("v%0d_wdata", i), bus.data_wdata, vecs[i].bus_wd);
      @(negedge clk);
      bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req_wait", i), {31'h0, bus.data_req}, 32'h0);
      chk($sformatf("v%0d_ready1", i), {31'h0, ready_mem}, 32'h1);
      chk($sformatf("v%0d_fwd_en", i), {31'h0, forward_mem_en}, {31'h0, ~vecs[i].st});
      if (!vecs[i].st) chk($sformatf("v%0d_fwd_data", i), forward_mem_wdata, vecs[i].res);
      @(negedge clk);
      bus.data_rvalid = 1'b0;
      lsu_en_mem = 1'b0; rd_wr_en_mem = 1'b0;
      chk($sformatf("v%0d_wb_en", i), {31'h0, rd_wr_en_wb}, {31'h0, ~vecs[i].st});
      chk($sformatf("v%0d_pc_wb", i), pc_wb, 32'h400 + 32'(i * 4));
      if (!vecs[i].st) chk($sformatf("v%0d_wb_data", i), rd_wr_data_wb, vecs[i].res);
    end

    // Non-LSU ALU result: single-cycle completion with forwarding.
    @(negedge clk); idle_inputs();
    rd_wr_en_mem = 1'b1; rd_wr_addr_mem = 5'd9; rd_wr_data_mem = 32'hCAFE_F00D; pc_mem = 32'h100;
    #1 chk("alu_req", {31'h0, bus.data_req}, 32'h0);
    chk("alu_ready", {31'h0, ready_mem}, 32'h1);
    chk("alu_fwd_en", {31'h0, forward_mem_en}, 32'h1);
    chk("alu_fwd_data", forward_mem_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("alu_wb_data", rd_wr_data_wb, 32'hCAFE_F00D);
    chk("alu_wb_addr", {27'h0, rd_wr_addr_wb}, 32'd9);
    chk("alu_pc_wb", pc_wb, 32'h100);

    // Misaligned LW: no bus request, exception recorded in one cycle.
    idle_inputs();
    drive_lsu(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h200);
    #1 chk("mis_req", {31'h0, bus.data_req}, 32'h0);
    chk("mis_ready", {31'h0, ready_mem}, 32'h1);
    chk("mis_fwd_en", {31'h0, forward_mem_en}, 32'h0);
    @(negedge clk);
    chk("mis_exc_wb", {31'h0, exc_taken_wb}, 32'h1);
    chk("mis_misaligned_wb", {31'h0, misaligned_wb}, 32'h1);
    chk("mis_wb_en", {31'h0, rd_wr_en_wb}, 32'h0);
    idle_inputs();
    @(negedge clk);
    chk("mis_clear_exc", {31'h0, exc_taken_wb}, 32'h0);

    // LW with grant three cycles late.
    drive_lsu(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h300);
    for (int c = 0; c < 4; c++) begin
      bus.data_gnt = (c == 3);
      #1;
      chk($sformatf("late_req_c%0d", c), {31'h0, bus.data_req}, 32'h1);
      chk($sformatf("late_addr_c%0d", c), bus.data_addr, 32'h0000_4000);
      chk($sformatf("late_ready_c%0d", c), {31'h0, ready_mem}, 32'h0);
      @(negedge clk);
    end
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h0BAD_F00D;
    #1 chk("late_ready_rv", {31'h0, ready_mem}, 32'h1);
    @(negedge clk);
    chk("late_wb_data", rd_wr_data_wb, 32'h0BAD_F00D);
    chk("late_wb_en", {31'h0, rd_wr_en_wb}, 32'h1);
    idle_inputs();

    // LW granted, flushed while waiting, response two cycles later must be dropped.
    @(negedge clk);
    drive_lsu(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h500);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    bus.data_gnt = 1'b0; flush_M = 1'b1;
    #1 chk("flush_ready_wait", {31'h0, ready_mem}, 32'h0);
    @(negedge clk);
    flush_M = 1'b0;
    #1 chk("drain_ready", {31'h0, ready_mem}, 32'h0);
    chk("drain_req", {31'h0, bus.data_req}, 32'h0);
    @(negedge clk);
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h7777_7777;
    #1 chk("drain_ready_rv", {31'h0, ready_mem}, 32'h0);
    @(negedge clk);
    bus.data_rvalid = 1'b0;
    chk("drain_no_wb", {31'h0, rd_wr_en_wb}, 32'h0);
    idle_inputs();
    #1 chk("drain_back_idle", {31'h0, ready_mem}, 32'h1);

    // LHU response arrives under stall; buffered data retires when stall drops.
    @(negedge clk);
    drive_lsu(1'b0, 3'b101, 32'h0000_6002, 32'h0, 32'h600);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    bus.data_gnt = 1'b0; stall_M = 1'b1; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h9876_ABCD;
    #1 chk("stall_ready_rv", {31'h0, ready_mem}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.data_rvalid = 1'b0; bus.data_rdata = 32'hDEAD_0000;
      #1 chk($sformatf("stall_ready_c%0d", c), {31'h0, ready_mem}, 32'h0);
      chk($sformatf("stall_wb_hold_c%0d", c), {31'h0, rd_wr_en_wb}, 32'h0);
    end
    @(negedge clk);
    stall_M = 1'b0;
    #1 chk("stall_release_ready", {31'h0, ready_mem}, 32'h1);
    chk("stall_fwd_data", forward_mem_wdata, 32'h0000_9876);
    @(negedge clk);
    chk("stall_wb_data", rd_wr_data_wb, 32'h0000_9876);
    chk("stall_wb_en", {31'h0, rd_wr_en_wb}, 32'h1);
    idle_inputs();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
